ex_stage: RTL and testbench

- Execute stage of the five-stage MIPS pipeline and the consumer of the decode stage's operation bundle: aluop, alusel, reg1, reg2, w_addr, we.
- Latches that bundle in an internal ID/EX register and computes logic, shift and arithmetic results.
- Runs a 32-iteration sequential divider for DIV/DIVU, holding the front of the pipeline with stall_o.
- Results go to the MEM stage: a GPR write bundle plus a HI/LO write bundle.

---
 rtl/ex_stage.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of a five-stage MIPS pipeline.
// Captures the decode bundle in an ID/EX register, computes logic, shift and
// arithmetic results, and runs a one-bit-per-cycle restoring divider for
// DIV/DIVU while holding the front of the pipeline through stall_o.
// Optional feature macro: EX_OVERFLOW_TRAP_EN adds signed ADD/SUB and the
// ov_o output; without it those opcodes are treated as unknown.
module ex_stage #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  w_addr_i,
  input  logic        we_i,
  output logic        stall_o,
  output logic [4:0]  w_addr_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
`ifdef EX_OVERFLOW_TRAP_EN
  ,
  output logic        ov_o
`endif
);

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;
  localparam logic [2:0] SEL_NOP   = 3'b000;

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h20;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUB  = 8'h22;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam int CW = $clog2(DIV_ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // ID/EX stage register
  logic [7:0]  aluop_r;
  logic [2:0]  alusel_r;
  logic [31:0] reg1_r;
  logic [31:0] reg2_r;
  logic [4:0]  w_addr_r;
  logic        we_r;

  // Divider state
  div_state_t  state_r;
  logic [CW-1:0] cnt_r;
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dvs_r;
  logic        neg_q_r;
  logic        neg_rem_r;

  logic        is_div_s;
  logic        signed_div_s;
  logic [31:0] dvd_mag_s;
  logic [31:0] dvs_mag_s;
  logic [32:0] trial_s;
  logic [32:0] diff_s;
  logic [31:0] step_rem_s;
  logic [31:0] step_quo_s;

  logic [31:0] result_s;
  logic        valid_s;
  logic [31:0] sum_s;
  logic [31:0] sub_s;
  logic [4:0]  sa_s;
`ifdef EX_OVERFLOW_TRAP_EN
  logic        ov_s;
`endif

  assign is_div_s     = (alusel_r == SEL_NOP) && ((aluop_r == OP_DIV) || (aluop_r == OP_DIVU));
  assign signed_div_s = (aluop_r == OP_DIV);
  assign dvd_mag_s    = (signed_div_s && reg1_r[31]) ? (32'h0 - reg1_r) : reg1_r;
  assign dvs_mag_s    = (signed_div_s && reg2_r[31]) ? (32'h0 - reg2_r) : reg2_r;
  assign sum_s        = reg1_r + reg2_r;
  assign sub_s        = reg1_r - reg2_r;
  assign sa_s         = reg1_r[4:0];

  // The pipeline front is held from capture of a divide until its result cycle
  assign stall_o = (state_r == BUSY) || ((state_r == IDLE) && is_div_s);

  // Capture the decode bundle unless the divider is holding the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      aluop_r  <= 8'h0;
      alusel_r <= 3'h0;
      reg1_r   <= 32'h0;
      reg2_r   <= 32'h0;
      w_addr_r <= 5'h0;
      we_r     <= 1'b0;
    end else if (!stall_o) begin
      aluop_r  <= aluop_i;
      alusel_r <= alusel_i;
      reg1_r   <= reg1_i;
      reg2_r   <= reg2_i;
      w_addr_r <= w_addr_i;
      we_r     <= we_i;
    end
  end

  // One restoring shift-subtract step: shift the next dividend bit into the remainder
  always_comb begin
    trial_s = {rem_r, quo_r[31]};
    diff_s  = trial_s - {1'b0, dvs_r};
    if (!diff_s[32]) begin
      step_rem_s = diff_s[31:0];
      step_quo_s = {quo_r[30:0], 1'b1};
    end else begin
      step_rem_s = trial_s[31:0];
      step_quo_s = {quo_r[30:0], 1'b0};
    end
  end

  // Divider FSM; quotient bits replace dividend bits in quo_r as they shift out
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      quo_r     <= 32'h0;
      rem_r     <= 32'h0;
      dvs_r     <= 32'h0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (is_div_s) begin
            if (reg2_r == 32'h0) begin
              // Divide by zero: all-ones quotient, dividend passed through as remainder
              state_r   <= DONE;
              quo_r     <= 32'hFFFF_FFFF;
              rem_r     <= reg1_r;
              neg_q_r   <= 1'b0;
              neg_rem_r <= 1'b0;
            end else begin
              state_r   <= BUSY;
              cnt_r     <= '0;
              quo_r     <= dvd_mag_s;
              rem_r     <= 32'h0;
              dvs_r     <= dvs_mag_s;
              neg_q_r   <= signed_div_s && (reg1_r[31] ^ reg2_r[31]);
              neg_rem_r <= signed_div_s && reg1_r[31];
            end
          end
        end
        BUSY: begin
          rem_r <= step_rem_s;
          quo_r <= step_quo_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          // The stage register advances on this same edge, so no re-entry
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // HI/LO bundle is only presented in the result cycle, with sign fixup applied
  always_comb begin
    if (state_r == DONE) begin
      whilo_o = 1'b1;
      lo_o    = neg_q_r ? (32'h0 - quo_r) : quo_r;
      hi_o    = neg_rem_r ? (32'h0 - rem_r) : rem_r;
    end else begin
      whilo_o = 1'b0;
      lo_o    = 32'h0;
      hi_o    = 32'h0;
    end
  end

  // GPR result selection; anything not decoded here produces no write
  always_comb begin
    result_s = 32'h0;
    valid_s  = 1'b0;
`ifdef EX_OVERFLOW_TRAP_EN
    ov_s     = 1'b0;
`endif
    case (alusel_r)
      SEL_LOGIC: begin
        case (aluop_r)
          OP_OR:   begin result_s = reg1_r | reg2_r;    valid_s = 1'b1; end
          OP_AND:  begin result_s = reg1_r & reg2_r;    valid_s = 1'b1; end
          OP_XOR:  begin result_s = reg1_r ^ reg2_r;    valid_s = 1'b1; end
          OP_NOR:  begin result_s = ~(reg1_r | reg2_r); valid_s = 1'b1; end
          default: begin result_s = 32'h0;              valid_s = 1'b0; end
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_r)
          OP_SLL:  begin result_s = reg2_r << sa_s; valid_s = 1'b1; end
          OP_SRL:  begin result_s = reg2_r >> sa_s; valid_s = 1'b1; end
          OP_SRA:  begin result_s = $unsigned($signed(reg2_r) >>> sa_s); valid_s = 1'b1; end
          default: begin result_s = 32'h0;          valid_s = 1'b0; end
        endcase
      end
      SEL_ARITH: begin
        case (aluop_r)
          OP_ADDU: begin result_s = sum_s; valid_s = 1'b1; end
          OP_SUBU: begin result_s = sub_s; valid_s = 1'b1; end
          OP_SLT:  begin result_s = {31'h0, ($signed(reg1_r) < $signed(reg2_r))}; valid_s = 1'b1; end
          OP_SLTU: begin result_s = {31'h0, (reg1_r < reg2_r)}; valid_s = 1'b1; end
`ifdef EX_OVERFLOW_TRAP_EN
          OP_ADD: begin
            result_s = sum_s;
            valid_s  = 1'b1;
            ov_s     = (reg1_r[31] == reg2_r[31]) && (sum_s[31] != reg1_r[31]);
          end
          OP_SUB: begin
            result_s = sub_s;
            valid_s  = 1'b1;
            ov_s     = (reg1_r[31] != reg2_r[31]) && (sub_s[31] != reg1_r[31]);
          end
`endif
          default: begin result_s = 32'h0; valid_s = 1'b0; end
        endcase
      end
      default: begin
        // NOP and divides never write a GPR
        result_s = 32'h0;
        valid_s  = 1'b0;
      end
    endcase
  end

  assign w_addr_o = w_addr_r;
  assign wdata_o  = valid_s ? result_s : 32'h0;
`ifdef EX_OVERFLOW_TRAP_EN
  assign we_o     = valid_s && we_r && !ov_s;
  assign ov_o     = ov_s;
`else
  assign we_o     = valid_s && we_r;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: expectations are queued when a bundle is
// driven and popped when the stage presents the result.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  w_addr_i;
  logic        we_i;
  logic        stall_o;
  logic [4:0]  w_addr_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        ov_w;
`ifdef EX_OVERFLOW_TRAP_EN
  logic        ov_o;
  assign ov_w = ov_o;
`else
  assign ov_w = 1'b0;
`endif

  always #5 clk = ~clk;

  ex_stage #(.DIV_ITER(32)) dut (
    .clk(clk), .rst(rst),
    .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .w_addr_i(w_addr_i), .we_i(we_i),
    .stall_o(stall_o), .w_addr_o(w_addr_o), .we_o(we_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
`ifdef EX_OVERFLOW_TRAP_EN
    , .ov_o(ov_o)
`endif
  );

  typedef struct {
    logic [31:0] wdata;
    logic        we;
    logic [4:0]  wa;
    logic        ov;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        wr;
  } vec_t;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model written from the operation table
  function automatic exp_t model(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] wa, input logic we);
    exp_t e;
    logic [31:0] r;
    logic v;
    logic ov;
    int sa_i, sb_i;
    r = 32'h0; v = 1'b0; ov = 1'b0;
    e.lo = 32'h0; e.hi = 32'h0; e.wa = wa;
    if (sel == 3'b001) begin
      if (op == 8'h25) begin r = a | b; v = 1'b1; end
      if (op == 8'h24) begin r = a & b; v = 1'b1; end
      if (op == 8'h26) begin r = a ^ b; v = 1'b1; end
      if (op == 8'h27) begin r = ~(a | b); v = 1'b1; end
    end else if (sel == 3'b010) begin
      if (op == 8'h7C) begin r = b << a[4:0]; v = 1'b1; end
      if (op == 8'h02) begin r = b >> a[4:0]; v = 1'b1; end
      if (op == 8'h03) begin r = $unsigned($signed(b) >>> a[4:0]); v = 1'b1; end
    end else if (sel == 3'b100) begin
      if (op == 8'h21) begin r = a + b; v = 1'b1; end
      if (op == 8'h23) begin r = a - b; v = 1'b1; end
      if (op == 8'h2A) begin r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0; v = 1'b1; end
      if (op == 8'h2B) begin r = (a < b) ? 32'h1 : 32'h0; v = 1'b1; end
`ifdef EX_OVERFLOW_TRAP_EN
      if (op == 8'h20) begin
        r = a + b; v = 1'b1;
        ov = ($signed(a) + 64'sd0 + $signed(b)) != $signed(r);
      end
      if (op == 8'h22) begin
        r = a - b; v = 1'b1;
        ov = ($signed(a) + 64'sd0 - $signed(b)) != $signed(r);
      end
`endif
    end else if (sel == 3'b000 && (op == 8'h1A || op == 8'h1B)) begin
      if (b == 32'h0) begin
        e.lo = 32'hFFFF_FFFF; e.hi = a;
      end else if (op == 8'h1B) begin
        e.lo = a / b; e.hi = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lo = 32'h8000_0000; e.hi = 32'h0;
      end else begin
        sa_i = a; sb_i = b;
        e.lo = sa_i / sb_i; e.hi = sa_i % sb_i;
      end
    end
    e.wdata = v ? r : 32'h0;
    e.we    = v && we && !ov;
    e.ov    = ov;
    return e;
  endfunction

  // Present one bundle at the falling edge and queue its expectation
  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa, input logic we, input exp_t e);
    @(negedge clk);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; w_addr_i = wa; we_i = we;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    aluop_i = 8'h25; alusel_i = 3'b001; reg1_i = 32'hFFFF; reg2_i = 32'h1; w_addr_i = 5'd7; we_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({stall_o, we_o, w_addr_o, wdata_o, whilo_o, hi_o, lo_o, ov_w} !== 105'h0) begin
      $display("FAIL reset_outputs got stall=%b we=%b wa=%0d wdata=%h whilo=%b hi=%h lo=%h ov=%b required all zero",
               stall_o, we_o, w_addr_o, wdata_o, whilo_o, hi_o, lo_o, ov_w);
    end else passed++;
    rst = 1'b0;
  endtask

  task automatic test_directed(input string name, input vec_t v[]);
    exp_t e, g;
    foreach (v[i]) begin
      e.wdata = v[i].res; e.we = v[i].wr; e.wa = 5'(i + 1); e.ov = 1'b0; e.lo = 32'h0; e.hi = 32'h0;
      drive(v[i].op, v[i].sel, v[i].a, v[i].b, 5'(i + 1), 1'b1, e);
      @(posedge clk); #1;
      g = sb_q.pop_front();
      total++;
      if ({stall_o, we_o, w_addr_o, wdata_o} !== {1'b0, g.we, g.wa, g.wdata}) begin
        $display("FAIL %s[%0d] got stall=%b we=%b wa=%0d wdata=%h required stall=0 we=%b wa=%0d wdata=%h",
                 name, i, stall_o, we_o, w_addr_o, wdata_o, g.we, g.wa, g.wdata);
      end else passed++;
    end
  endtask

  task automatic test_logic();
    vec_t v[] = new[5];
    v[0] = '{8'h25, 3'b001, 32'h0000_1100, 32'h0000_0020, 32'h0000_1120, 1'b1};
    v[1] = '{8'h24, 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1};
    v[2] = '{8'h26, 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1};
    v[3] = '{8'h27, 3'b001, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    v[4] = '{8'h27, 3'b001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1};
    test_directed("logic", v);
  endtask

  task automatic test_shift_arith();
    vec_t v[] = new[10];
    v[0] = '{8'h03, 3'b010, 32'h0000_0004, 32'hF000_0000, 32'hFF00_0000, 1'b1};
    v[1] = '{8'h02, 3'b010, 32'h0000_0004, 32'hF000_0000, 32'h0F00_0000, 1'b1};
    v[2] = '{8'h7C, 3'b010, 32'h0000_003F, 32'h0000_0003, 32'h8000_0000, 1'b1};
    v[3] = '{8'h2A, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1};
    v[4] = '{8'h2B, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    v[5] = '{8'h21, 3'b100, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1};
    v[6] = '{8'h23, 3'b100, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
    v[7] = '{8'h25, 3'b011, 32'h1234_5678, 32'h1, 32'h0, 1'b0};
    v[8] = '{8'h55, 3'b001, 32'h1234_5678, 32'h1, 32'h0, 1'b0};
    v[9] = '{8'h24, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0};
    test_directed("shift_arith", v);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops[19]  = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'h21, 8'h23, 8'h2A,
                            8'h2B, 8'h20, 8'h22, 8'h25, 8'h7C, 8'h55, 8'h21, 8'h24, 8'h2A};
    logic [2:0] sels[19] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100,
                            3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100, 3'b011, 3'b000, 3'b111};
    logic [31:0] corner[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    exp_t g;
    int k;
    logic [31:0] a, b;
    logic [4:0] wa;
    logic we;
    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 18);
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      wa = 5'($urandom_range(0, 31));
      we = 1'($urandom_range(0, 3) != 0);
      drive(ops[k], sels[k], a, b, wa, we, model(ops[k], sels[k], a, b, wa, we));
      @(posedge clk); #1;
      g = sb_q.pop_front();
      total++;
      if ({stall_o, we_o, w_addr_o, wdata_o, ov_w, whilo_o} !== {1'b0, g.we, g.wa, g.wdata, g.ov, 1'b0}) begin
        $display("FAIL b2b[%0d] op=%h sel=%b a=%h b=%h got we=%b wa=%0d wdata=%h ov=%b stall=%b required we=%b wa=%0d wdata=%h ov=%b",
                 n, ops[k], sels[k], a, b, we_o, w_addr_o, wdata_o, ov_w, stall_o, g.we, g.wa, g.wdata, g.ov);
      end else passed++;
    end
  endtask

  task automatic test_div();
    logic [31:0] da[7] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 32'h0000_1234, 32'd5, 32'h7FFF_FFFF};
    logic [31:0] db[7] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd3, 32'h0, 32'h0, 32'h7FFF_FFFF};
    logic [7:0]  dop[7] = '{8'h1A, 8'h1A, 8'h1A, 8'h1B, 8'h1B, 8'h1A, 8'h1B};
    exp_t g;
    int n;
    int need;
    logic bad_mid;
    for (int i = 0; i < 7; i++) begin
      drive(dop[i], 3'b000, da[i], db[i], 5'd3, 1'b1, model(dop[i], 3'b000, da[i], db[i], 5'd3, 1'b1));
      @(posedge clk); #1;
      n = 0; bad_mid = 1'b0;
      while (stall_o === 1'b1 && n < 100) begin
        if (whilo_o !== 1'b0 || we_o !== 1'b0) bad_mid = 1'b1;
        n++;
        @(posedge clk); #1;
      end
      need = (db[i] == 32'h0) ? 1 : 33;
      total++;
      if (n != need) $display("FAIL div_stall[%0d] got %0d cycles required %0d", i, n, need);
      else passed++;
      total++;
      if (bad_mid) $display("FAIL div_busy_out[%0d] got whilo/we asserted while stalled required 0", i);
      else passed++;
      g = sb_q.pop_front();
      total++;
      if ({whilo_o, we_o, lo_o, hi_o} !== {1'b1, 1'b0, g.lo, g.hi}) begin
        $display("FAIL div_result[%0d] got whilo=%b we=%b lo=%h hi=%h required whilo=1 we=0 lo=%h hi=%h",
                 i, whilo_o, we_o, lo_o, hi_o, g.lo, g.hi);
      end else passed++;
      // Next bundle must be captured on the edge that ends the result cycle
      drive(8'h25, 3'b001, 32'(i), 32'h100, 5'd9, 1'b1, model(8'h25, 3'b001, 32'(i), 32'h100, 5'd9, 1'b1));
      @(posedge clk); #1;
      g = sb_q.pop_front();
      total++;
      if ({stall_o, whilo_o, we_o, wdata_o} !== {1'b0, 1'b0, g.we, g.wdata}) begin
        $display("FAIL div_next[%0d] got stall=%b whilo=%b we=%b wdata=%h required stall=0 whilo=0 we=%b wdata=%h",
                 i, stall_o, whilo_o, we_o, wdata_o, g.we, g.wdata);
      end else passed++;
    end
  endtask

  task automatic test_rst_mid_div();
    exp_t g;
    drive(8'h1B, 3'b000, 32'd1000, 32'd3, 5'd4, 1'b0, model(8'h1B, 3'b000, 32'd1000, 32'd3, 5'd4, 1'b0));
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    void'(sb_q.pop_front());
    total++;
    if ({stall_o, we_o, w_addr_o, wdata_o, whilo_o, hi_o, lo_o, ov_w} !== 105'h0) begin
      $display("FAIL rst_mid_div got stall=%b we=%b wa=%0d wdata=%h whilo=%b hi=%h lo=%h required all zero",
               stall_o, we_o, w_addr_o, wdata_o, whilo_o, hi_o, lo_o);
    end else passed++;
    rst = 1'b0;
    drive(8'h25, 3'b001, 32'h0000_1100, 32'h0000_0020, 5'd5, 1'b1, model(8'h25, 3'b001, 32'h0000_1100, 32'h0000_0020, 5'd5, 1'b1));
    @(posedge clk); #1;
    g = sb_q.pop_front();
    total++;
    if ({stall_o, we_o, w_addr_o, wdata_o} !== {1'b0, 1'b1, 5'd5, 32'h0000_1120}) begin
      $display("FAIL rst_then_or got stall=%b we=%b wa=%0d wdata=%h required stall=0 we=1 wa=5 wdata=%h",
               stall_o, we_o, w_addr_o, wdata_o, g.wdata);
    end else passed++;
  endtask

  task automatic test_overflow();
    exp_t g;
    logic [31:0] need_w[4] = '{32'h8000_0000, 32'd8, 32'h7FFF_FFFF, 32'd2};
    logic        need_we[4];
    logic        need_ov[4];
    logic [31:0] oa[4] = '{32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'd5};
    logic [31:0] ob[4] = '{32'd1, 32'd3, 32'd1, 32'd3};
    logic [7:0]  oo[4] = '{8'h20, 8'h20, 8'h22, 8'h22};
`ifdef EX_OVERFLOW_TRAP_EN
    need_we = '{1'b0, 1'b1, 1'b0, 1'b1};
    need_ov = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    need_we = '{1'b0, 1'b0, 1'b0, 1'b0};
    need_ov = '{1'b0, 1'b0, 1'b0, 1'b0};
    need_w  = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(oo[i], 3'b100, oa[i], ob[i], 5'd12, 1'b1, model(oo[i], 3'b100, oa[i], ob[i], 5'd12, 1'b1));
      @(posedge clk); #1;
      g = sb_q.pop_front();
      total++;
      if ({ov_w, we_o} !== {need_ov[i], need_we[i]}) begin
        $display("FAIL ovf[%0d] got ov=%b we=%b required ov=%b we=%b", i, ov_w, we_o, need_ov[i], need_we[i]);
      end else passed++;
      if (need_we[i] || !need_ov[i]) begin
        total++;
        if (wdata_o !== need_w[i]) $display("FAIL ovf_data[%0d] got %h required %h", i, wdata_o, need_w[i]);
        else passed++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    aluop_i = 8'h0; alusel_i = 3'h0; reg1_i = 32'h0; reg2_i = 32'h0; w_addr_i = 5'h0; we_i = 1'b0;
    test_reset();
    test_logic();
    test_shift_arith();
    test_back_to_back();
    test_rst_mid_div();
    test_div();
    test_overflow();
    total++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain got %0d entries required 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
